// File: rtl/data_mem_burst_ctrl.sv
// data_mem_burst_ctrl
// Burst access controller in front of a synchronous single-cycle-latency data
// memory. It takes one burst command at a time and then either streams write
// beats into the memory or streams read beats back out through a 4-entry
// first-word-fall-through response buffer.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   req_valid/req_ready      command handshake (req_write, req_addr, req_len)
//   wr_valid/wr_ready        write beat handshake (wr_data)
//   rd_valid/rd_ready        read beat handshake (rd_data)
//   busy, done               burst in progress / one-cycle completion pulse
//   Read_enable, Write_enable, Address, Write_data   registered memory strobes
//   Data_out                 memory read data, valid the cycle after Read_enable
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 16
`endif

module data_mem_burst_ctrl #(
  parameter int ADDR_BITS = 13,
  parameter int DATA_BITS = `INTERNAL_BITS,
  parameter int LEN_BITS  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LEN_BITS-1:0]  req_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 Read_enable,
  output logic                 Write_enable,
  output logic [ADDR_BITS-1:0] Address,
  output logic [DATA_BITS-1:0] Write_data,
  input  logic [DATA_BITS-1:0] Data_out
);

  localparam int CNT_BITS = LEN_BITS + 1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0]  CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [ADDR_BITS-1:0]   cur_addr_r;      // next address to write or to issue a read to
  logic [CNT_BITS-1:0]    total_r;
  logic [CNT_BITS-1:0]    accepted_r;
  logic [CNT_BITS-1:0]    issued_r;
  logic [CNT_BITS-1:0]    delivered_r;
  logic                   re_r, we_r;
  logic [ADDR_BITS-1:0]   addr_r;
  logic [DATA_BITS-1:0]   wdata_r;
  logic                   infl_r;          // Data_out carries a requested word this cycle
  logic [DATA_BITS-1:0]   fifo_r [4];
  logic [1:0]             wptr_r, rptr_r;
  logic [2:0]             count_r;

  logic                   req_hs_s, wr_hs_s, pop_s, push_s, issue_s;
  logic [3:0]             occ_nxt_s;

  assign req_ready    = (state_r == IDLE) && !RST;
  assign wr_ready     = (state_r == WRITE) && (accepted_r < total_r) && !RST;
  assign rd_valid     = (count_r != 3'd0);
  assign rd_data      = rd_valid ? fifo_r[rptr_r] : {DATA_BITS{1'b0}};
  assign busy         = (state_r != IDLE);
  assign done         = (state_r == DONE);
  assign Read_enable  = re_r;
  assign Write_enable = we_r;
  assign Address      = addr_r;
  assign Write_data   = wdata_r;

  assign req_hs_s = req_valid && req_ready;
  assign wr_hs_s  = wr_valid && wr_ready;
  assign pop_s    = rd_valid && rd_ready && (state_r == READ);
  assign push_s   = infl_r;

  // Read_enable is registered, so the decision made now is for next cycle's
  // strobe. Project the buffer occupancy plus words still in flight after
  // this edge (buffer after push/pop, plus the strobe currently on the bus)
  // so that all outstanding words always fit in the 4-entry buffer.
  assign occ_nxt_s = {1'b0, count_r} + {3'b000, infl_r} + {3'b000, re_r} - {3'b000, pop_s};
  assign issue_s   = (state_r == READ) && (issued_r < total_r) && (occ_nxt_s < 4'd4);

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_hs_s) begin
          state_nxt_s = req_write ? WRITE : READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (wr_hs_s && ((accepted_r + CNT_ONE) == total_r)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      READ: begin
        if (pop_s && ((delivered_r + CNT_ONE) == total_r)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = READ;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst counters and registered memory interface.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_addr_r  <= {ADDR_BITS{1'b0}};
      total_r     <= {CNT_BITS{1'b0}};
      accepted_r  <= {CNT_BITS{1'b0}};
      issued_r    <= {CNT_BITS{1'b0}};
      delivered_r <= {CNT_BITS{1'b0}};
      re_r        <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= {ADDR_BITS{1'b0}};
      wdata_r     <= {DATA_BITS{1'b0}};
    end else begin
      re_r <= 1'b0;
      we_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_hs_s) begin
            total_r     <= {1'b0, req_len} + CNT_ONE;
            accepted_r  <= {CNT_BITS{1'b0}};
            delivered_r <= {CNT_BITS{1'b0}};
            if (req_write) begin
              cur_addr_r <= req_addr;
              issued_r   <= {CNT_BITS{1'b0}};
            end else begin
              // First read strobe goes out in the first READ cycle.
              re_r       <= 1'b1;
              addr_r     <= req_addr;
              cur_addr_r <= req_addr + ADDR_ONE;
              issued_r   <= CNT_ONE;
            end
          end
        end
        WRITE: begin
          if (wr_hs_s) begin
            we_r       <= 1'b1;
            addr_r     <= cur_addr_r;
            wdata_r    <= wr_data;
            cur_addr_r <= cur_addr_r + ADDR_ONE;
            accepted_r <= accepted_r + CNT_ONE;
          end
        end
        READ: begin
          if (issue_s) begin
            re_r       <= 1'b1;
            addr_r     <= cur_addr_r;
            cur_addr_r <= cur_addr_r + ADDR_ONE;
            issued_r   <= issued_r + CNT_ONE;
          end
          if (pop_s) begin
            delivered_r <= delivered_r + CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Response buffer: capture Data_out the cycle after each strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      infl_r  <= 1'b0;
      wptr_r  <= 2'd0;
      rptr_r  <= 2'd0;
      count_r <= 3'd0;
    end else begin
      infl_r <= re_r;
      if (push_s) begin
        fifo_r[wptr_r] <= Data_out;
        wptr_r         <= wptr_r + 2'd1;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + 2'd1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_burst_ctrl.sv
`timescale 1ns/1ps
module tb_data_mem_burst_ctrl;

  localparam int AB = 13;
  localparam int DB = 16;
  localparam int LB = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid, req_ready, req_write;
  logic [AB-1:0] req_addr;
  logic [LB-1:0] req_len;
  logic          wr_valid, wr_ready;
  logic [DB-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DB-1:0] rd_data;
  logic          busy, done;
  logic          Read_enable, Write_enable;
  logic [AB-1:0] Address;
  logic [DB-1:0] Write_data;
  logic [DB-1:0] Data_out;

  int checks = 0;
  int errors = 0;

  logic [DB-1:0] mem [0:(1<<AB)-1];
  logic [DB-1:0] wbuf [8];
  logic [DB-1:0] rbuf [8];

  always #5 CLK = ~CLK;

  data_mem_burst_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .LEN_BITS(LB)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .Read_enable(Read_enable), .Write_enable(Write_enable),
    .Address(Address), .Write_data(Write_data), .Data_out(Data_out)
  );

  // Synchronous memory with 1-cycle read latency.
  always @(posedge CLK) begin
    if (Write_enable) mem[Address] <= Write_data;
    if (Read_enable)  Data_out <= mem[Address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_burst(input logic [AB-1:0] a, input int n, input string tg);
    logic [AB-1:0] ea;
    chk({tg, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = LB'(n - 1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tg, "_wr_ready"}, 32'(wr_ready), 32'd1);
      wr_valid = 1'b1; wr_data = wbuf[i];
      tick();
      ea = a + AB'(i);
      chk({tg, "_we"}, 32'(Write_enable), 32'd1);
      chk({tg, "_re"}, 32'(Read_enable), 32'd0);
      chk({tg, "_addr"}, 32'(Address), 32'(ea));
      chk({tg, "_wdata"}, 32'(Write_data), 32'(wbuf[i]));
      chk({tg, "_done"}, 32'(done), (i == n - 1) ? 32'd1 : 32'd0);
      chk({tg, "_busy"}, 32'(busy), 32'd1);
    end
    chk({tg, "_wr_ready_done"}, 32'(wr_ready), 32'd0);
    wr_valid = 1'b0;
    tick();
    chk({tg, "_post_done"}, 32'(done), 32'd0);
    chk({tg, "_post_we"}, 32'(Write_enable), 32'd0);
    chk({tg, "_post_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic read_burst(input logic [AB-1:0] a, input int n, input string tg);
    logic [AB-1:0] ea;
    chk({tg, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = LB'(n - 1);
    rd_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= n + 3; k++) begin
      chk({tg, "_re"}, 32'(Read_enable), (k <= n) ? 32'd1 : 32'd0);
      chk({tg, "_we"}, 32'(Write_enable), 32'd0);
      if (k <= n) begin
        ea = a + AB'(k - 1);
        chk({tg, "_addr"}, 32'(Address), 32'(ea));
      end
      chk({tg, "_rd_valid"}, 32'(rd_valid), (k >= 3 && k <= n + 2) ? 32'd1 : 32'd0);
      if (k >= 3 && k <= n + 2) begin
        chk({tg, "_rd_data"}, 32'(rd_data), 32'(rbuf[k - 3]));
      end
      chk({tg, "_done"}, 32'(done), (k == n + 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk({tg, "_post_busy"}, 32'(busy), 32'd0);
    chk({tg, "_post_re"}, 32'(Read_enable), 32'd0);
    rd_ready = 1'b0;
  endtask

  initial begin
    int re_cnt;
    int cyc;
    int got;

    // 1. Reset with a pending command.
    RST = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 13'd5; req_len = 8'd0;
    wr_valid = 1'b0; wr_data = 16'd0; rd_ready = 1'b0;
    #1;
    chk("rst_req_ready0", 32'(req_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_re", 32'(Read_enable), 32'd0);
      chk("rst_we", 32'(Write_enable), 32'd0);
      chk("rst_addr", 32'(Address), 32'd0);
      chk("rst_wdata", 32'(Write_data), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    RST = 1'b0; req_valid = 1'b0;
    #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);

    // 2. Write burst: addr 10, 4 beats.
    wbuf[0] = 16'd100; wbuf[1] = 16'd99; wbuf[2] = 16'd98; wbuf[3] = 16'd97;
    write_burst(13'd10, 4, "wr10");

    // 3. Read it back with no backpressure.
    rbuf[0] = 16'd100; rbuf[1] = 16'd99; rbuf[2] = 16'd98; rbuf[3] = 16'd97;
    read_burst(13'd10, 4, "rd10");

    // 4. Backpressure: preload i at address i, then stall the consumer.
    for (int i = 0; i < 8; i++) wbuf[i] = DB'(i);
    write_burst(13'd0, 8, "wr0");
    rd_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 13'd0; req_len = 8'd7;
    tick();
    req_valid = 1'b0;
    re_cnt = 0; cyc = 0;
    while (!rd_valid && cyc < 10) begin
      re_cnt += 32'(Read_enable);
      tick();
      cyc++;
    end
    chk("bp_first_valid", 32'(rd_valid), 32'd1);
    for (int s = 0; s < 6; s++) begin
      re_cnt += 32'(Read_enable);
      chk("bp_hold_valid", 32'(rd_valid), 32'd1);
      chk("bp_hold_data", 32'(rd_data), 32'd0);
      tick();
    end
    chk("bp_re_le4", (re_cnt <= 4) ? 32'd1 : 32'd0, 32'd1);
    rd_ready = 1'b1; got = 0; cyc = 0;
    while (!done && cyc < 40) begin
      if (rd_valid) begin
        chk("bp_data", 32'(rd_data), 32'(got));
        got++;
      end
      tick();
      cyc++;
    end
    chk("bp_done_seen", 32'(done), 32'd1);
    chk("bp_count", 32'(got), 32'd8);
    chk("bp_done_rd_valid", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;
    tick();
    chk("bp_post_busy", 32'(busy), 32'd0);

    // 5. Address wrap: 8190, 8191, 0.
    wbuf[0] = 16'd5; wbuf[1] = 16'd6; wbuf[2] = 16'd7;
    write_burst(13'd8190, 3, "wrwrap");
    rbuf[0] = 16'd5; rbuf[1] = 16'd6; rbuf[2] = 16'd7;
    read_burst(13'd8190, 3, "rdwrap");

    // 6. Reset mid-read after two beats delivered; mem[0] is now 7.
    rd_ready = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 13'd0; req_len = 8'd7;
    tick();                      // c1
    req_valid = 1'b0;
    tick();                      // c2
    tick();                      // c3
    chk("mr_beat0_valid", 32'(rd_valid), 32'd1);
    chk("mr_beat0_data", 32'(rd_data), 32'd7);
    tick();                      // c4
    chk("mr_beat1_data", 32'(rd_data), 32'd1);
    tick();                      // c5
    chk("mr_beat2_data", 32'(rd_data), 32'd2);
    RST = 1'b1;
    #1;
    chk("mr_rst_req_ready", 32'(req_ready), 32'd0);
    tick();                      // c6
    RST = 1'b0;
    chk("mr_re", 32'(Read_enable), 32'd0);
    chk("mr_we", 32'(Write_enable), 32'd0);
    chk("mr_rd_valid", 32'(rd_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    #1;
    rbuf[0] = 16'd7;
    read_burst(13'd0, 1, "rdafter");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_burst_ctrl.md
Name: data_mem_burst_ctrl

Overview:
Burst access controller sitting directly upstream of the data memory; it is the only agent driving the memory's Read_enable/Write_enable/Address/Write_data.
- Accepts one burst command at a time (start address, beat count, direction) over a valid/ready handshake.
- Streams write beats into memory, or streams read beats out through a 4-entry response buffer with backpressure.
- Hides the memory's 1-cycle synchronous read latency from the consumer.

Parameters:
ADDR_BITS, 13, memory word-address width; addresses wrap modulo 2^ADDR_BITS
DATA_BITS, `INTERNAL_BITS, data word width
LEN_BITS, 8, width of req_len; burst = req_len+1 beats (1..256)

Ports:
CLK  input  1  single clock; all state updates on rising edge (drive memory CLKA/CLKB from same net)
RST  input  1  synchronous active-high reset
req_valid  input  1  burst command valid
req_ready  output  1  controller idle, command accepted on valid&ready
req_write  input  1  1 = write burst, 0 = read burst
req_addr  input  ADDR_BITS  burst start address
req_len  input  LEN_BITS  beats minus one
wr_valid  input  1  write beat valid
wr_ready  output  1  write beat accepted on valid&ready
wr_data  input  DATA_BITS  write beat data
rd_valid  output  1  read beat valid
rd_ready  input  1  consumer accepts read beat
rd_data  output  DATA_BITS  read beat data
busy  output  1  burst in progress (state != IDLE)
done  output  1  one-cycle pulse at burst completion
Read_enable  output  1  memory read strobe (registered)
Write_enable  output  1  memory write strobe (registered)
Address  output  ADDR_BITS  memory address (registered)
Write_data  output  DATA_BITS  memory write data (registered)
Data_out  input  DATA_BITS  memory read data, valid the cycle after Read_enable

Behaviour:
- Reset, synchronous, wins over everything:
  - state IDLE; counters and buffer cleared.
  - Outputs: Read_enable, Write_enable, Address, Write_data, rd_valid, rd_data, done, busy = 0.
  - req_ready = 0 and wr_ready = 0 while RST high.
  - Reset mid-burst aborts immediately: no memory strobe in the cycle after reset, buffered/in-flight read data discarded.
- FSM: IDLE -> WRITE | READ -> DONE -> IDLE.
- IDLE:
  - req_ready = 1.
  - On handshake, latch cur_addr = req_addr and total = req_len+1, clear counters, then go to WRITE or READ per req_write.
- WRITE:
  - wr_ready = 1 while beats_accepted < total.
  - Each wr handshake in cycle t produces, in cycle t+1: Write_enable = 1, Address = cur_addr, Write_data = wr_data; cur_addr then increments.
  - With no handshake, Write_enable = 0 the next cycle.
  - After the last beat handshake, go to DONE; the last memory write occurs in the DONE cycle.
- READ:
  - Issue condition: issued < total AND (buffer occupancy + in-flight) < 4.
  - When issuing in cycle t: Read_enable = 1, Address = cur_addr, increment cur_addr.
  - Data_out is sampled at the end of cycle t+1 and pushed into the FIFO; it is visible at rd_valid/rd_data in cycle t+2.
  - FIFO output is first-word-fall-through. rd_data and rd_valid hold stable while rd_valid & !rd_ready.
  - Beats are delivered strictly in address order.
  - Go to DONE when delivered == total.
- DONE:
  - done = 1 for exactly one cycle; busy = 1; then IDLE.
  - No back-to-back command acceptance in the DONE cycle.
- Read_enable and Write_enable are never 1 in the same cycle. Both are 0 in IDLE, and 0 in the cycle after DONE except for a trailing write.
- Address increment wraps 2^ADDR_BITS-1 -> 0 silently.
- wr_valid in READ/IDLE is ignored (wr_ready = 0). rd_ready outside READ is ignored.
- Full throughput: one beat per cycle in both directions with no backpressure.

Test Plan:
1. Reset: RST high 2 cycles with req_valid = 1 -> all outputs 0, no accept; after release req_ready = 1, busy = 0.
2. Write burst: addr 10, len 3, wr_data 100,99,98,97 on consecutive cycles -> Write_enable high 4 consecutive cycles, Address 10,11,12,13, Write_data matches; done pulses once coincident with the Address 13 write.
3. Read back: addr 10, len 3, rd_ready = 1, request accepted cycle c0 -> Read_enable high c1..c4 (Address 10..13), rd_valid high c3..c6, rd_data 100,99,98,97, done in c7.
4. Backpressure: read addr 0, len 7, memory preloaded with i at address i, rd_ready = 0 for 6 cycles after first rd_valid -> at most 4 Read_enable pulses before first pop, rd_data held at 0 while stalled, final sequence 0..7 with none lost or duplicated.
5. Wrap: write addr 8190, len 2, data 5,6,7 -> Address 8190, 8191, 0; a read of the same burst returns 5,6,7.
6. Reset mid-read: RST for 1 cycle after 2 of 8 beats delivered -> next cycle Read_enable = 0, rd_valid = 0, busy = 0; a new read of addr 0 len 0 returns the memory[0] value correctly.
